// File: rtl/led_tick_counter.sv
// rtl/led_tick_counter.sv - prescaled LED pattern generator with up/down/bounce/rotate modes
module led_tick_counter #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             tick,
  output logic             wrap
);

  // Clock cycles per LED update; the prescaler counts 0..DIV-1.
  localparam int               DIV        = CLK_FREQ / TICK_HZ;
  localparam logic [31:0]      PRESC_LAST = 32'(DIV - 1);
  localparam logic [WIDTH-1:0] LEDS_MAX   = '1;
  localparam logic [WIDTH-1:0] LEDS_ZERO  = '0;
  localparam logic [WIDTH-1:0] LEDS_ONE   = WIDTH'(1);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  logic [31:0]      r_presc;
  logic [WIDTH-1:0] r_leds;
  logic             r_dir;
  logic             r_tick;
  logic             r_wrap;

  logic             w_step;
  logic [WIDTH-1:0] w_nxt_leds;
  logic             w_nxt_dir;
  logic             w_nxt_wrap;

  // A step fires on the last prescaler count of an enabled cycle; with DIV=1 that is every enabled cycle.
  assign w_step = en && (r_presc == PRESC_LAST);

  // Pattern that a step would produce from the current LEDs, direction and mode.
  always_comb begin
    w_nxt_leds = r_leds;
    w_nxt_dir  = r_dir;
    w_nxt_wrap = 1'b0;
    case (mode)
      MODE_UP: begin
        w_nxt_leds = r_leds + LEDS_ONE;
        w_nxt_wrap = (r_leds == LEDS_MAX);
      end
      MODE_DOWN: begin
        w_nxt_leds = r_leds - LEDS_ONE;
        w_nxt_wrap = (r_leds == LEDS_ZERO);
      end
      MODE_BOUNCE: begin
        if (!r_dir) begin
          if (r_leds == LEDS_MAX) begin
            w_nxt_leds = LEDS_MAX - LEDS_ONE;
            w_nxt_dir  = 1'b1;
            w_nxt_wrap = 1'b1;
          end else begin
            w_nxt_leds = r_leds + LEDS_ONE;
          end
        end else begin
          if (r_leds == LEDS_ZERO) begin
            w_nxt_leds = LEDS_ONE;
            w_nxt_dir  = 1'b0;
            w_nxt_wrap = 1'b1;
          end else begin
            w_nxt_leds = r_leds - LEDS_ONE;
          end
        end
      end
      default: begin
        // An all-zero pattern would rotate forever as zero, so seed a single lit LED instead.
        if (r_leds == LEDS_ZERO) begin
          w_nxt_leds = LEDS_ONE;
        end else begin
          w_nxt_leds = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
          w_nxt_wrap = r_leds[WIDTH-1];
        end
      end
    endcase
  end

  // Prescaler, LED state and pulse outputs; reset beats load, load beats a coincident step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_leds  <= '0;
      r_dir   <= 1'b0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_presc <= '0;
      r_leds  <= load_val;
      r_dir   <= 1'b0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_presc <= '0;
      r_leds  <= w_nxt_leds;
      r_dir   <= w_nxt_dir;
      r_tick  <= 1'b1;
      r_wrap  <= w_nxt_wrap;
    end else begin
      if (en) begin
        r_presc <= r_presc + 32'd1;
      end
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign leds = r_leds;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_tick_counter.sv
// tb/tb_led_tick_counter.sv - model-checked random and directed bench for led_tick_counter
module tb_led_tick_counter;

  localparam int CLK_FREQ = 4;
  localparam int TICK_HZ  = 1;
  localparam int WIDTH    = 4;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int MAXV     = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] leds;
  logic             tick;
  logic             wrap;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  int m_cnt  = 0;
  int m_leds = 0;
  int m_dir  = 0;
  int m_tick = 0;
  int m_wrap = 0;

  int ticks, wraps, first_tick;

  led_tick_counter #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .leds    (leds),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: counts enabled cycles since the last step and applies each mode's rule arithmetically
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_leds = 0; m_dir = 0; m_tick = 0; m_wrap = 0;
    end else if (load) begin
      m_cnt = 0; m_leds = int'(load_val); m_dir = 0; m_tick = 0; m_wrap = 0;
    end else if (en) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == DIV) begin
        m_cnt  = 0;
        m_tick = 1;
        m_wrap = 0;
        case (mode)
          2'b00: begin
            m_wrap = (m_leds == MAXV) ? 1 : 0;
            m_leds = (m_leds + 1) % (MAXV + 1);
          end
          2'b01: begin
            m_wrap = (m_leds == 0) ? 1 : 0;
            m_leds = (m_leds + MAXV) % (MAXV + 1);
          end
          2'b10: begin
            if (m_dir == 0 && m_leds == MAXV) begin
              m_leds = MAXV - 1; m_dir = 1; m_wrap = 1;
            end else if (m_dir == 1 && m_leds == 0) begin
              m_leds = 1; m_dir = 0; m_wrap = 1;
            end else if (m_dir == 0) begin
              m_leds = m_leds + 1;
            end else begin
              m_leds = m_leds - 1;
            end
          end
          default: begin
            if (m_leds == 0) begin
              m_leds = 1;
            end else begin
              m_wrap = (m_leds >= (MAXV + 1) / 2) ? 1 : 0;
              m_leds = (m_leds * 2) % (MAXV + 1) + m_leds / ((MAXV + 1) / 2);
            end
          end
        endcase
      end else begin
        m_tick = 0; m_wrap = 0;
      end
    end else begin
      m_tick = 0; m_wrap = 0;
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("leds", 32'(leds), 32'(m_leds));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("wrap_without_tick", 32'(wrap & ~tick), 32'd0);
    end
  end

  task automatic do_load(input logic [WIDTH-1:0] v, input logic [1:0] md);
    load = 1'b1; load_val = v; mode = md; en = 1'b0;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
  endtask

  task automatic wait_tick();
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (tick) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tick_timeout: got no tick expected tick within 40 cycles at %0t", $time);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] rot_exp [5];
    logic             rot_wrap [5];

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);

    // count up over a full 16-step cycle
    rst = 1'b0; en = 1'b1; mode = 2'b00;
    ticks = 0; wraps = 0; first_tick = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
        chk("up_seq", 32'(leds), 32'(ticks % 16));
      end
      if (wrap) begin
        wraps++;
        chk("up_wrap_at_zero", 32'(leds), 32'd0);
      end
    end
    chk("up_ticks", 32'(ticks), 32'd16);
    chk("up_wraps", 32'(wraps), 32'd1);
    chk("up_first_tick", 32'(first_tick), 32'd4);

    // down from zero
    do_load(4'h0, 2'b01);
    wait_tick();
    chk("down_first_leds", 32'(leds), 32'hF);
    chk("down_first_wrap", 32'(wrap), 32'd1);
    wait_tick();
    chk("down_second_leds", 32'(leds), 32'hE);
    chk("down_second_wrap", 32'(wrap), 32'd0);

    // bounce through both reversals
    do_load(4'hE, 2'b10);
    wait_tick();
    chk("bounce_f", 32'(leds), 32'hF);
    chk("bounce_f_wrap", 32'(wrap), 32'd0);
    wait_tick();
    chk("bounce_e", 32'(leds), 32'hE);
    chk("bounce_e_wrap", 32'(wrap), 32'd1);
    wraps = 0;
    for (int i = 0; i < 15; i++) begin
      wait_tick();
      if (wrap) wraps++;
    end
    chk("bounce_low_leds", 32'(leds), 32'h1);
    chk("bounce_low_wrap", 32'(wrap), 32'd1);
    chk("bounce_wrap_count", 32'(wraps), 32'd1);

    // rotate seeded from zero
    rot_exp  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    rot_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_load(4'h0, 2'b11);
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      chk("rot_leds", 32'(leds), 32'(rot_exp[i]));
      chk("rot_wrap", 32'(wrap), 32'(rot_wrap[i]));
    end

    // enable gap at prescaler 2, then load on a step edge
    do_load(4'h5, 2'b00);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_tick", 32'(tick), 32'd0);
      chk("hold_leds", 32'(leds), 32'h5);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_early_tick", 32'(tick), 32'd0);
    @(negedge clk);
    chk("resume_tick", 32'(tick), 32'd1);
    chk("resume_leds", 32'(leds), 32'h6);
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 4'h9;
    @(negedge clk);
    load = 1'b0;
    chk("load_on_step_leds", 32'(leds), 32'h9);
    chk("load_on_step_tick", 32'(tick), 32'd0);

    // reset at prescaler 3
    do_load(4'h3, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_leds", 32'(leds), 32'd0);
    chk("midrst_tick", 32'(tick), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_early_tick", 32'(tick), 32'd0);
    end
    @(negedge clk);
    chk("midrst_tick_after_4", 32'(tick), 32'd1);
    chk("midrst_leds_after_4", 32'(leds), 32'd1);

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 9) != 0);
      load_val = WIDTH'($urandom_range(0, MAXV));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
